// File: rtl/kw_fifo_pkg.sv
// -----------------------------------------------------------------------------
// kw_fifo_pkg
// Shared types and constants for the FIFO read-side adapter.
//   POP_BUF_DEPTH    : number of entries in the output buffer
//   pop_level_t      : buffered-word count type (0..2)
//   rd_latency_legal : elaboration-time check of the RAM read latency parameter
// -----------------------------------------------------------------------------
package kw_fifo_pkg;

    localparam int POP_BUF_DEPTH = 2;

    typedef logic [1:0] pop_level_t;

    // Only combinational (0) or single-register (1) RAM reads are supported.
    function automatic bit rd_latency_legal(input int lat);
        return (lat == 0) || (lat == 1);
    endfunction

endpackage

// File: rtl/kw_buf2.sv
// -----------------------------------------------------------------------------
// kw_buf2
// Two-entry in-order register buffer. The head entry is always the oldest word.
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   wr_en_i   : append wr_data_i behind the current contents
//   wr_data_i : word to append
//   rd_en_i   : drop the head entry (ignored while empty)
//   flush_i   : synchronous clear, wins over write and read
//   head_o    : oldest buffered word (registered)
//   valid_o   : buffer holds at least one word
//   count_o   : number of buffered words, 0..2
// -----------------------------------------------------------------------------
module kw_buf2
    import kw_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic                  valid_o,
    output pop_level_t            count_o
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    pop_level_t            count_q, count_d;
    logic                  rd_eff;

    assign rd_eff = rd_en_i && (count_q != '0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            case ({wr_en_i, rd_eff})
                2'b10: begin
                    if (count_q == '0) head_d = wr_data_i;
                    else               tail_d = wr_data_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous write and read: level stays, order is kept by
                    // shifting the tail forward before the new word lands.
                    if (count_q == 2'd1) begin
                        head_d = wr_data_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = wr_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/kw_fifo_pop_stream.sv
// -----------------------------------------------------------------------------
// kw_fifo_pop_stream
// Read-side adapter: turns the FIFO controller's pop interface into a
// valid/ready stream. A 2-entry output buffer plus credit-based pop issue
// hides the RAM read latency and sustains one word per cycle.
//   clock        : clock, rising edge
//   reset_n      : asynchronous active-low reset
//   fifo_empty   : FIFO controller level is zero
//   fifo_pop_req : pop request to the FIFO controller
//   fifo_data    : FIFO read data, RD_LATENCY cycles after the pop
//   flush        : synchronous discard of buffered and in-flight words
//   m_valid      : output word valid
//   m_ready      : downstream accepts
//   m_data       : output word (head of buffer)
//   level        : buffered word count, 0..2
// -----------------------------------------------------------------------------
module kw_fifo_pop_stream
    import kw_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  fifo_empty,
    output logic                  fifo_pop_req,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output pop_level_t            level
);

    if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
        $fatal(1, "kw_fifo_pop_stream: RD_LATENCY must be 0 or 1");
    end

    logic       inflight_q, inflight_d;
    logic       drop_q, drop_d;
    logic       deq;
    logic       buf_wr;
    logic [2:0] occ;

    assign deq = m_valid && m_ready;

    // Credits: buffered plus in-flight words may never exceed the buffer depth.
    // A same-cycle dequeue frees a slot, which keeps the stream bubble-free.
    assign occ = {1'b0, level} + {2'b00, inflight_q};
    assign fifo_pop_req = reset_n && !fifo_empty && !flush &&
                          ((occ < 3'(POP_BUF_DEPTH)) || deq);

    always_comb begin
        inflight_d = 1'b0;
        drop_d     = 1'b0;
        buf_wr     = 1'b0;
        if (RD_LATENCY == 0) begin
            buf_wr = fifo_pop_req;
        end else begin
            // Exactly one pop can be outstanding, issued in the previous cycle.
            inflight_d = fifo_pop_req;
            // A word already in flight when flush hits is discarded; drop_q
            // masks the write path for the cycle after that flush.
            drop_d     = flush && inflight_q;
            buf_wr     = inflight_q && !drop_q && !flush;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    kw_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .wr_en_i   (buf_wr),
        .wr_data_i (fifo_data),
        .rd_en_i   (deq),
        .flush_i   (flush),
        .head_o    (m_data),
        .valid_o   (m_valid),
        .count_o   (level)
    );

endmodule

// File: tb/tb_kw_fifo_pop_stream.sv
// -----------------------------------------------------------------------------
// tb_kw_fifo_pop_stream
// Drives one RD_LATENCY=0 and one RD_LATENCY=1 instance side by side, each fed
// by its own behavioural FIFO, and compares every cycle against a reference
// model built from the stream rules (word list, credit count, flush discard).
// -----------------------------------------------------------------------------
module tb_kw_fifo_pop_stream;

    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          fifo_empty   [2];
    logic          fifo_pop_req [2];
    logic [DW-1:0] fifo_data    [2];
    logic          flush        [2];
    logic          m_valid      [2];
    logic          m_ready      [2];
    logic [DW-1:0] m_data       [2];
    logic [1:0]    level        [2];

    always #5 clock = ~clock;

    // Behavioural FIFO controllers (ring memory, pointers, registered read for lat 1)
    logic [DW-1:0] mem [2][1024];
    int            wr_ptr [2];
    int            rd_ptr [2];
    logic [DW-1:0] val    [2];
    logic [DW-1:0] rdata1;

    assign fifo_empty[0] = (wr_ptr[0] == rd_ptr[0]);
    assign fifo_empty[1] = (wr_ptr[1] == rd_ptr[1]);
    assign fifo_data[0]  = mem[0][rd_ptr[0][9:0]];
    assign fifo_data[1]  = rdata1;

    kw_fifo_pop_stream #(.DATA_WIDTH(DW), .RD_LATENCY(0)) u_dut0 (
        .clock        (clock),
        .reset_n      (reset_n),
        .fifo_empty   (fifo_empty[0]),
        .fifo_pop_req (fifo_pop_req[0]),
        .fifo_data    (fifo_data[0]),
        .flush        (flush[0]),
        .m_valid      (m_valid[0]),
        .m_ready      (m_ready[0]),
        .m_data       (m_data[0]),
        .level        (level[0])
    );

    kw_fifo_pop_stream #(.DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut1 (
        .clock        (clock),
        .reset_n      (reset_n),
        .fifo_empty   (fifo_empty[1]),
        .fifo_pop_req (fifo_pop_req[1]),
        .fifo_data    (fifo_data[1]),
        .flush        (flush[1]),
        .m_valid      (m_valid[1]),
        .m_ready      (m_ready[1]),
        .m_data       (m_data[1]),
        .level        (level[1])
    );

    // Reference model: buffered word list, pending (in-flight) word
    logic [DW-1:0] rq [2][2];
    int            rcnt [2];
    bit            rpend [2];
    logic [DW-1:0] rpend_data [2];
    bit            dut_pop_prev [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel;
    int first_valid [2];
    int first_deq   [2];
    int last_deq    [2];
    int pops        [2];
    int delivered   [2];
    logic [DW-1:0] first_data [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            mem[k][wr_ptr[k][9:0]] = val[k];
            val[k] = val[k] + 16'd1;
            wr_ptr[k]++;
        end
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 2; k++) begin
            first_valid[k] = -1;
            first_deq[k]   = -1;
            last_deq[k]    = -1;
            pops[k]        = 0;
            delivered[k]   = 0;
            first_data[k]  = '0;
        end
    endtask

    // One clock cycle: sample and check at the falling edge, advance the
    // reference model, then let the FIFO models react just after the rising edge.
    task automatic tick();
        bit            exp_pop, deq, wr;
        bit            popped [2];
        logic [DW-1:0] wd;
        int            occ;
        @(negedge clock);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            popped[k] = fifo_pop_req[k];
            if (!reset_n) begin
                check($sformatf("L%0d pop_in_reset", k), 32'(fifo_pop_req[k]), 32'd0);
                rcnt[k] = 0;
                rpend[k] = 1'b0;
                popped[k] = 1'b0;
                continue;
            end
            occ     = rcnt[k] + (rpend[k] ? 1 : 0);
            deq     = (rcnt[k] != 0) && m_ready[k];
            exp_pop = !fifo_empty[k] && !flush[k] && ((occ < 2) || deq);
            check($sformatf("L%0d pop_req", k), 32'(fifo_pop_req[k]), 32'(exp_pop));
            check($sformatf("L%0d pop_while_empty", k), 32'(fifo_pop_req[k] && fifo_empty[k]), 32'd0);
            check($sformatf("L%0d level", k), 32'(level[k]), 32'(rcnt[k]));
            check($sformatf("L%0d m_valid", k), 32'(m_valid[k]), 32'(rcnt[k] != 0));
            if (rcnt[k] != 0)
                check($sformatf("L%0d m_data", k), 32'(m_data[k]), 32'(rq[k][0]));
            check($sformatf("L%0d occ_le2", k),
                  32'((int'(level[k]) + ((k == 1 && dut_pop_prev[k]) ? 1 : 0)) <= 2), 32'd1);

            if (m_valid[k] && first_valid[k] < 0) first_valid[k] = cyc;
            if (fifo_pop_req[k]) pops[k]++;
            if (m_valid[k] && m_ready[k]) begin
                if (delivered[k] == 0) begin
                    first_data[k] = m_data[k];
                    first_deq[k]  = cyc;
                end
                last_deq[k] = cyc;
                delivered[k]++;
            end

            wr = 1'b0;
            wd = '0;
            if (k == 0 && exp_pop) begin
                wr = 1'b1;
                wd = mem[0][rd_ptr[0][9:0]];
            end
            if (k == 1 && rpend[1]) begin
                wr = 1'b1;
                wd = rpend_data[1];
            end
            if (flush[k]) begin
                rcnt[k] = 0;
            end else begin
                if (deq) begin
                    rq[k][0] = rq[k][1];
                    rcnt[k]--;
                end
                if (wr && rcnt[k] < 2) begin
                    rq[k][rcnt[k]] = wd;
                    rcnt[k]++;
                end
            end
            rpend[k]      = (k == 1) && exp_pop;
            rpend_data[k] = mem[k][rd_ptr[k][9:0]];
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            dut_pop_prev[k] = popped[k];
            if (k == 1) rdata1 = popped[1] ? mem[1][rd_ptr[1][9:0]] : DW'($urandom);
            if (popped[k]) rd_ptr[k]++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        rel = cyc;
    endtask

    initial begin
        reset_n = 1'b0;
        rdata1  = '0;
        for (int k = 0; k < 2; k++) begin
            wr_ptr[k] = 0;
            rd_ptr[k] = 0;
            val[k] = 16'd1;
            m_ready[k] = 1'b1;
            flush[k] = 1'b0;
            rcnt[k] = 0;
            rpend[k] = 1'b0;
            dut_pop_prev[k] = 1'b0;
        end
        clear_stats();

        // Reset state with a non-empty FIFO
        for (int k = 0; k < 2; k++) push(k, 8);
        #2;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("L%0d rst m_valid", k), 32'(m_valid[k]), 32'd0);
            check($sformatf("L%0d rst level", k), 32'(level[k]), 32'd0);
            check($sformatf("L%0d rst m_data", k), 32'(m_data[k]), 32'd0);
            check($sformatf("L%0d rst pop_req", k), 32'(fifo_pop_req[k]), 32'd0);
        end
        @(posedge clock);
        #1;

        // Eight preloaded words, downstream always ready
        do_reset();
        repeat (14) tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("L%0d first_valid_latency", k), 32'(first_valid[k] - (rel + 1)), 32'(k + 1));
            check($sformatf("L%0d stream_pops", k), 32'(pops[k]), 32'd8);
            check($sformatf("L%0d stream_delivered", k), 32'(delivered[k]), 32'd8);
            check($sformatf("L%0d stream_no_bubbles", k), 32'(last_deq[k] - first_deq[k]), 32'd7);
            check($sformatf("L%0d stream_first", k), 32'(first_data[k]), 32'h0001);
        end

        // Backpressure: five words, ten stalled cycles, then release
        clear_stats();
        for (int k = 0; k < 2; k++) begin
            val[k] = 16'd1;
            push(k, 5);
            m_ready[k] = 1'b0;
        end
        do_reset();
        repeat (10) tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("L%0d stall_pops", k), 32'(pops[k]), 32'd2);
            check($sformatf("L%0d stall_level", k), 32'(level[k]), 32'd2);
            check($sformatf("L%0d stall_m_data", k), 32'(m_data[k]), 32'h0001);
            check($sformatf("L%0d stall_m_valid", k), 32'(m_valid[k]), 32'd1);
            m_ready[k] = 1'b1;
        end
        repeat (10) tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("L%0d stall_delivered", k), 32'(delivered[k]), 32'd5);
            check($sformatf("L%0d stall_no_gaps", k), 32'(last_deq[k] - first_deq[k]), 32'd4);
            check($sformatf("L%0d stall_first", k), 32'(first_data[k]), 32'h0001);
        end

        // Flush while a word is buffered and another is in flight
        clear_stats();
        for (int k = 0; k < 2; k++) begin
            val[k] = 16'd1;
            push(k, 4);
            m_ready[k] = 1'b0;
        end
        do_reset();
        repeat (2) tick();
        for (int k = 0; k < 2; k++) flush[k] = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            flush[k] = 1'b0;
            check($sformatf("L%0d flush_level", k), 32'(level[k]), 32'd0);
            check($sformatf("L%0d flush_m_valid", k), 32'(m_valid[k]), 32'd0);
            m_ready[k] = 1'b1;
        end
        repeat (8) tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("L%0d flush_next_word", k), 32'(first_data[k]), 32'h0003);
            check($sformatf("L%0d flush_delivered", k), 32'(delivered[k]), 32'd2);
        end

        // Randomized traffic: ready, producer pushes and occasional flushes
        for (int n = 0; n < 10000; n++) begin
            for (int k = 0; k < 2; k++) begin
                m_ready[k] = 1'($urandom_range(0, 1));
                flush[k]   = ($urandom_range(0, 49) == 0);
                if ((wr_ptr[k] - rd_ptr[k]) < 12 && $urandom_range(0, 1) == 1) push(k, 1);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            m_ready[k] = 1'b1;
            flush[k] = 1'b0;
        end
        repeat (30) tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("L%0d drain_level", k), 32'(level[k]), 32'd0);
            check($sformatf("L%0d drain_fifo_empty", k), 32'(fifo_empty[k]), 32'd1);
        end

        // Asynchronous reset in the middle of a stalled stream
        clear_stats();
        for (int k = 0; k < 2; k++) begin
            val[k] = 16'd1;
            push(k, 6);
            m_ready[k] = 1'b0;
        end
        repeat (4) tick();
        for (int k = 0; k < 2; k++)
            check($sformatf("L%0d pre_reset_level", k), 32'(level[k]), 32'd2);
        reset_n = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("L%0d async_m_valid", k), 32'(m_valid[k]), 32'd0);
            check($sformatf("L%0d async_level", k), 32'(level[k]), 32'd0);
            check($sformatf("L%0d async_pop_req", k), 32'(fifo_pop_req[k]), 32'd0);
        end
        clear_stats();
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 2; k++) m_ready[k] = 1'b1;
        repeat (12) tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("L%0d restart_delivered", k), 32'(delivered[k]), 32'd4);
            check($sformatf("L%0d restart_first", k), 32'(first_data[k]), 32'h0003);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
